// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM states, frame size, parity.
// Used by both the host transmitter and the keyboard deserializer.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_SEND,
    ST_ACK,
    ST_RELEASE
  } ps2_state_t;

  // data + parity + stop
  localparam int FRAME_BITS = 10;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for one PS/2 line plus falling-edge flag.
// Lines idle high, so the flops reset to 1 to avoid a false edge.
module ps2_line_sync (
  input  logic clock,
  input  logic reset,
  input  logic line,
  output logic level,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // synchronise and keep one cycle of history
  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= line;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign fall  = ~sync & prev;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter.
// Inhibit, request-to-send, device-clocked bits, ACK check.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       START,
  input  logic [7:0] DATA,
  input  logic       PS2_CLK_IN,
  input  logic       PS2_DATA_IN,
  output logic       PS2_CLK_OE,
  output logic       PS2_DATA_OE,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERROR
);

  localparam int MAX_CYC =
    (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
    INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] INH_LAST =
    CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] INH_END =
    CW'(INHIBIT_CYCLES);
  localparam logic [CW-1:0] TO_LAST =
    CW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] LAST_IDX =
    4'(FRAME_BITS - 1);

  ps2_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] bit_idx, idx_n;
  logic [8:0] shreg, sh_n;
  logic ok, ok_n;
  logic clk_oe_n, data_oe_n;
  logic busy_n, done_n, error_n;

  logic clk_level, clk_fall;
  logic data_level, data_fall_unused;
  logic watch, expire, lines_idle;
  logic [9:0] frame;
  logic frame_bit;

  ps2_line_sync u_clk_sync (
    .clock (clock),
    .reset (reset),
    .line  (PS2_CLK_IN),
    .level (clk_level),
    .fall  (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .clock (clock),
    .reset (reset),
    .line  (PS2_DATA_IN),
    .level (data_level),
    .fall  (data_fall_unused)
  );

  assign watch = (state == ST_SEND) |
                 (state == ST_ACK) |
                 (state == ST_RELEASE);
  assign expire = watch & ~clk_fall &
                  (cnt == TO_LAST);
  assign lines_idle = clk_level & data_level;
  assign frame = {1'b1, shreg};
  assign frame_bit = frame[bit_idx];

  // state and datapath registers; outputs come from flops
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      ok          <= 1'b0;
      PS2_CLK_OE  <= 1'b0;
      PS2_DATA_OE <= 1'b0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      ERROR       <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bit_idx     <= idx_n;
      shreg       <= sh_n;
      ok          <= ok_n;
      PS2_CLK_OE  <= clk_oe_n;
      PS2_DATA_OE <= data_oe_n;
      BUSY        <= busy_n;
      DONE        <= done_n;
      ERROR       <= error_n;
    end
  end

  // next-state selection
  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:
        if (START) state_n = ST_INHIBIT;
      ST_INHIBIT:
        if (cnt == INH_END) state_n = ST_SEND;
      ST_SEND:
        if (clk_fall && bit_idx == LAST_IDX)
          state_n = ST_ACK;
        else if (expire)
          state_n = ST_IDLE;
      ST_ACK:
        if (clk_fall) state_n = ST_RELEASE;
        else if (expire) state_n = ST_IDLE;
      ST_RELEASE:
        if (lines_idle || expire)
          state_n = ST_IDLE;
      default:
        state_n = ST_IDLE;
    endcase
  end

  // datapath and output next values
  always_comb begin
    cnt_n     = cnt;
    idx_n     = bit_idx;
    sh_n      = shreg;
    ok_n      = ok;
    clk_oe_n  = PS2_CLK_OE;
    data_oe_n = PS2_DATA_OE;
    busy_n    = BUSY;
    done_n    = 1'b0;
    error_n   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (START) begin
          sh_n      = {odd_parity(DATA), DATA};
          busy_n    = 1'b1;
          clk_oe_n  = 1'b1;
          data_oe_n = 1'b0;
          cnt_n     = '0;
        end
      end
      ST_INHIBIT: begin
        cnt_n = cnt + CW'(1);
        if (cnt == INH_LAST) data_oe_n = 1'b1;
        if (cnt == INH_END) begin
          clk_oe_n = 1'b0;
          cnt_n    = '0;
          idx_n    = '0;
        end
      end
      ST_SEND, ST_ACK: begin
        if (clk_fall) begin
          cnt_n = '0;
          if (state == ST_SEND) begin
            data_oe_n = ~frame_bit;
            idx_n     = bit_idx + 4'd1;
          end else begin
            ok_n = ~data_level;
          end
        end else if (expire) begin
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b0;
          busy_n    = 1'b0;
          error_n   = 1'b1;
          cnt_n     = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_RELEASE: begin
        if (lines_idle) begin
          done_n  = ok;
          error_n = ~ok;
          busy_n  = 1'b0;
          cnt_n   = '0;
        end else if (clk_fall) begin
          cnt_n = '0;
        end else if (expire) begin
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b0;
          busy_n    = 1'b0;
          error_n   = 1'b1;
          cnt_n     = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain device model.
// Device clocks at 20 cycles/bit and samples data on rising edges.
module tb_ps2_host_tx;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       START = 1'b0;
  logic [7:0] DATA  = 8'h00;
  logic       PS2_CLK_OE;
  logic       PS2_DATA_OE;
  logic       BUSY;
  logic       DONE;
  logic       ERROR;

  logic dev_clk  = 1'b1;
  logic dev_data = 1'b1;
  wire  clk_line  = ~PS2_CLK_OE & dev_clk;
  wire  data_line = ~PS2_DATA_OE & dev_data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_fall_cyc = 0;

  int done_cnt = 0;
  int err_cnt = 0;
  int err_cyc = 0;
  logic done_busy, err_busy;
  logic [1:0] done_oe, err_oe, err_lines;

  ps2_host_tx #(
    .INHIBIT_CYCLES (8),
    .TIMEOUT_CYCLES (200)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .START       (START),
    .DATA        (DATA),
    .PS2_CLK_IN  (clk_line),
    .PS2_DATA_IN (data_line),
    .PS2_CLK_OE  (PS2_CLK_OE),
    .PS2_DATA_OE (PS2_DATA_OE),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .ERROR       (ERROR)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (DONE) begin
      done_cnt  = done_cnt + 1;
      done_busy = BUSY;
      done_oe   = {PS2_CLK_OE, PS2_DATA_OE};
    end
    if (ERROR) begin
      err_cnt   = err_cnt + 1;
      err_cyc   = cyc;
      err_busy  = BUSY;
      err_oe    = {PS2_CLK_OE, PS2_DATA_OE};
      err_lines = {clk_line, data_line};
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic start_tx(input logic [7:0] d);
    @(negedge clock);
    START = 1'b1;
    DATA  = d;
    @(negedge clock);
    START = 1'b0;
  endtask

  // waits for request-to-send, then clocks nclk bits (+ack if 10)
  task automatic device_frame(input bit ack,
                              input int nclk,
                              output logic [10:0] bits);
    int w;
    bits = '0;
    w = 0;
    while (!(PS2_CLK_OE == 1'b0 && data_line == 1'b0)
           && w < 100) begin
      @(negedge clock);
      w++;
    end
    check("rts_seen", 32'(w < 100), 32'd1);
    if (w >= 100) return;
    repeat (10) @(negedge clock);
    for (int i = 0; i < nclk; i++) begin
      if (i == 0) bits[0] = data_line;
      dev_clk = 1'b0;
      last_fall_cyc = cyc;
      repeat (10) @(negedge clock);
      dev_clk = 1'b1;
      bits[i+1] = data_line;
      repeat (10) @(negedge clock);
    end
    if (nclk == 10) begin
      dev_data = ack ? 1'b0 : 1'b1;
      repeat (5) @(negedge clock);
      dev_clk = 1'b0;
      repeat (10) @(negedge clock);
      dev_clk = 1'b1;
      repeat (5) @(negedge clock);
      dev_data = 1'b1;
    end
  endtask

  logic [10:0] bits;
  int d0, e0, w, dt;

  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_clk_oe", PS2_CLK_OE, 0);
    check("rst_data_oe", PS2_DATA_OE, 0);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_error", ERROR, 0);

    // 1: 0xED with ACK
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hED);
    check("t1_busy", BUSY, 1);
    check("t1_clk_oe", PS2_CLK_OE, 1);
    device_frame(1'b1, 10, bits);
    repeat (30) @(negedge clock);
    check("t1_start", bits[0], 0);
    check("t1_byte", bits[8:1], 32'hED);
    check("t1_parity", bits[9], 1);
    check("t1_stop", bits[10], 1);
    check("t1_done", done_cnt - d0, 1);
    check("t1_noerr", err_cnt - e0, 0);
    check("t1_busy_at_done", done_busy, 0);
    check("t1_oe_at_done", done_oe, 0);

    // 2: parity extremes
    d0 = done_cnt;
    start_tx(8'h00);
    device_frame(1'b1, 10, bits);
    repeat (30) @(negedge clock);
    check("t2a_byte", bits[8:1], 32'h00);
    check("t2a_parity", bits[9], 1);
    start_tx(8'h01);
    device_frame(1'b1, 10, bits);
    repeat (30) @(negedge clock);
    check("t2b_byte", bits[8:1], 32'h01);
    check("t2b_parity", bits[9], 0);
    check("t2_done", done_cnt - d0, 2);

    // 3: NACK
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hED);
    device_frame(1'b0, 10, bits);
    repeat (30) @(negedge clock);
    check("t3_err", err_cnt - e0, 1);
    check("t3_nodone", done_cnt - d0, 0);
    check("t3_busy_at_err", err_busy, 0);
    check("t3_lines_idle", err_lines, 2'b11);

    // 4: device stops after bit 3
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hED);
    device_frame(1'b1, 4, bits);
    w = 0;
    while (err_cnt == e0 && w < 400) begin
      @(negedge clock);
      w++;
    end
    check("t4_timeout", err_cnt - e0, 1);
    dt = err_cyc - last_fall_cyc;
    check("t4_latency", 32'(dt >= 195 && dt <= 215), 1);
    check("t4_oe_at_err", err_oe, 0);
    check("t4_busy", BUSY, 0);
    check("t4_nodone", done_cnt - d0, 0);
    start_tx(8'h3C);
    device_frame(1'b1, 10, bits);
    repeat (30) @(negedge clock);
    check("t4_retry_byte", bits[8:1], 32'h3C);
    check("t4_retry_done", done_cnt - d0, 1);

    // 5: START during SEND is ignored
    d0 = done_cnt;
    start_tx(8'hED);
    fork
      device_frame(1'b1, 10, bits);
      begin
        repeat (80) @(negedge clock);
        START = 1'b1;
        DATA  = 8'h55;
        @(negedge clock);
        START = 1'b0;
      end
    join
    repeat (60) @(negedge clock);
    check("t5_byte", bits[8:1], 32'hED);
    check("t5_parity", bits[9], 1);
    check("t5_done", done_cnt - d0, 1);
    check("t5_idle", BUSY, 0);

    // 6: reset mid-SEND at bit 5
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hED);
    device_frame(1'b1, 6, bits);
    reset = 1'b1;
    @(negedge clock);
    check("t6_clk_oe", PS2_CLK_OE, 0);
    check("t6_data_oe", PS2_DATA_OE, 0);
    check("t6_busy", BUSY, 0);
    reset = 1'b0;
    repeat (30) @(negedge clock);
    check("t6_nodone", done_cnt - d0, 0);
    check("t6_noerr", err_cnt - e0, 0);
    start_tx(8'hF4);
    device_frame(1'b1, 10, bits);
    repeat (30) @(negedge clock);
    check("t6_byte", bits[8:1], 32'hF4);
    check("t6_parity", bits[9], 0);
    check("t6_done", done_cnt - d0, 1);

    // START together with reset: reset wins
    reset = 1'b1;
    START = 1'b1;
    DATA  = 8'hAA;
    @(negedge clock);
    START = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    check("rst_start_busy", BUSY, 0);
    check("rst_start_clk_oe", PS2_CLK_OE, 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends one command byte to the keyboard, for example 0xED for LED set or 0xFF for reset. It is the transmit counterpart of the keyboard deserializer.
- Drives the open-drain PS2_CLK/PS2_DATA lines through active-high "pull low" enables.
- Follows the inhibit / request-to-send / device-clocked sequence.
- Reports DONE on a valid device ACK, and ERROR on NACK or timeout.

Parameters:
- INHIBIT_CYCLES, 5000: clock cycles PS2_CLK is held low before the request (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000: maximum cycles between consecutive device falling edges, and for the final line release (15 ms at 50 MHz).

Ports:
- clock, input, 1: system clock; all logic is on its rising edge.
- reset, input, 1: synchronous, active-high.
- START, input, 1: one-cycle request. Sampled only when BUSY=0.
- DATA, input, 8: byte to send. Captured in the cycle START is accepted.
- PS2_CLK_IN, input, 1: PS/2 clock line level (asynchronous).
- PS2_DATA_IN, input, 1: PS/2 data line level (asynchronous).
- PS2_CLK_OE, output, 1: 1 = drive PS2_CLK low, 0 = release.
- PS2_DATA_OE, output, 1: 1 = drive PS2_DATA low, 0 = release.
- BUSY, output, 1: high from START acceptance until DONE/ERROR.
- DONE, output, 1: one-cycle pulse when the device ACK is received.
- ERROR, output, 1: one-cycle pulse on NACK or timeout.

Behaviour:
Reset
- Outputs: PS2_CLK_OE=0, PS2_DATA_OE=0, BUSY=0, DONE=0, ERROR=0.
- State: IDLE, counters 0, shift register 0.
- Reset mid-transfer releases both lines on the next clock edge. No DONE or ERROR is produced.

Input synchronisation
- PS2_CLK_IN and PS2_DATA_IN each pass through a 2-flop synchroniser.
- A falling edge is flagged (clk_fall, 1 cycle) when synced clock = 0 and its registered previous value = 1.

States and transitions
- IDLE
  - START=1 latches DATA and parity = ~^DATA (odd).
  - Sets BUSY=1 and PS2_CLK_OE=1, then goes to INHIBIT.
- INHIBIT
  - Counts INHIBIT_CYCLES cycles, then sets PS2_DATA_OE=1 (start bit).
  - Next cycle sets PS2_CLK_OE=0 and goes to SEND with bit index 0.
- SEND
  - On each clk_fall, PS2_DATA_OE = ~bit.
  - Bit order is data[0..7] (LSB first), then parity, then stop. The stop bit sets OE=0.
  - The OE update is registered one cycle after clk_fall.
  - After the stop bit is placed (10th clk_fall), go to ACK.
- ACK
  - On the next clk_fall, sample synced PS2_DATA_IN.
  - 0 = ack: go to RELEASE with ok=1.
  - 1 = nack: go to RELEASE with ok=0.
- RELEASE
  - Waits until synced clock = 1 and synced data = 1.
  - Then pulses DONE (if ok) or ERROR (if not), and clears BUSY in the same cycle.
  - Returns to IDLE.

Timeout
- In SEND, ACK and RELEASE, a watchdog clears on every clk_fall.
- If it reaches TIMEOUT_CYCLES, the block releases both OEs, pulses ERROR, clears BUSY and returns to IDLE.

Boundary rules
- START while BUSY=1 is ignored; DATA is not re-captured.
- START coinciding with reset: reset wins.
- Device traffic in progress at START acceptance: the host has priority. INHIBIT proceeds regardless, which aborts the device frame per protocol.
- Glitch-free outputs: OE signals come straight from flops.
- Bit counter width: 4 bits, values 0–10.
- Counters are sized as clog2(max(INHIBIT_CYCLES, TIMEOUT_CYCLES)+1).

Decomposition:
- Package ps2_pkg holds:
  - the state enum (IDLE, INHIBIT, SEND, ACK, RELEASE);
  - the constant FRAME_BITS=10 (data + parity + stop);
  - an odd-parity function.
  The deserializer shares this package.
- One sub-module, ps2_line_sync: 2-flop synchroniser plus falling-edge detector for one line. It is instantiated for PS2_CLK_IN and PS2_DATA_IN (edge output unused for data). It is reusable by the receiver.

Test Plan:
Bench settings: INHIBIT_CYCLES=8 and TIMEOUT_CYCLES=200. A device model generates a 20-cycle-period PS2_CLK after seeing PS2_CLK released with data low.

1. Send DATA=0xED. The device samples on rising edges and ACKs → start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1. DONE pulses once, BUSY falls the same cycle, both OE=0.
2. Send DATA=0x00 → parity bit 1 on the line. Send 0x01 → parity 0. Both transfers end in DONE.
3. The device leaves data high on the 11th fall (NACK) → ERROR pulses once, DONE stays 0, BUSY falls after the lines are idle.
4. The device stops clocking after bit 3 → ERROR 200 cycles after the last fall, both OE=0, state IDLE. A fresh START then succeeds.
5. START pulsed again during SEND with DATA=0x55 → ignored. The original byte 0xED completes unchanged with exactly one DONE.
6. Assert reset during SEND at bit 5 → next cycle both OE=0, BUSY=0, no DONE/ERROR. A START after reset sends 0xF4 correctly.
